// File: rtl/axis_frame_pkg.sv
// Shared types and header field layout for the AXI-Stream frame builder.
package axis_frame_pkg;

    localparam int unsigned SEQ_W       = 8;
    localparam int unsigned CSUM_W      = 16;
    localparam int unsigned HDR_SEQ_MSB = 15;
    localparam int unsigned HDR_SEQ_LSB = 8;
    localparam int unsigned HDR_LEN_MSB = 7;
    localparam int unsigned HDR_LEN_LSB = 0;

`ifdef AXIS_FRAME_BUILDER_CSUM_EN
    typedef enum logic [1:0] {StHdr, StPay, StCsum} frame_state_t;
`else
    typedef enum logic [1:0] {StHdr, StPay} frame_state_t;
`endif

endpackage

// File: rtl/axis_frame_builder.sv
// Cuts an unframed sample stream into PKT_LEN-word frames with a seq/length header word.
// Define AXIS_FRAME_BUILDER_CSUM_EN to append a 16-bit payload checksum word to each frame.
module axis_frame_builder
    import axis_frame_pkg::*;
#(
    parameter int unsigned WIDTH_TDATA = 16,
    parameter int unsigned WIDTH_TUSER = 4,
    parameter int unsigned PKT_LEN     = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   axis_s_tvalid,
    input  logic [WIDTH_TDATA-1:0] axis_s_tdata,
    input  logic [WIDTH_TUSER-1:0] axis_s_tuser,
    output logic                   axis_s_tready,
    output logic                   axis_m_tvalid,
    output logic [WIDTH_TDATA-1:0] axis_m_tdata,
    output logic [WIDTH_TUSER-1:0] axis_m_tuser,
    output logic                   axis_m_tlast,
    input  logic                   axis_m_tready
);

    localparam int unsigned WCNT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(PKT_LEN - 1);
    localparam logic [7:0] LEN_FIELD = 8'(PKT_LEN - 1);

    frame_state_t state_q, state_d;
    logic [SEQ_W-1:0] seq_q, seq_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic valid_q, valid_d;
    logic [WIDTH_TDATA-1:0] data_q, data_d;
    logic [WIDTH_TUSER-1:0] user_q, user_d;
    logic last_q, last_d;
`ifdef AXIS_FRAME_BUILDER_CSUM_EN
    logic [CSUM_W-1:0] csum_q, csum_d;
`endif

    logic slot_free;

    assign slot_free     = !valid_q || axis_m_tready;
    assign axis_s_tready = !rst && (state_q == StPay) && slot_free;

    assign axis_m_tvalid = valid_q;
    assign axis_m_tdata  = data_q;
    assign axis_m_tuser  = user_q;
    assign axis_m_tlast  = last_q;

    always_comb begin
        state_d = state_q;
        seq_d   = seq_q;
        wcnt_d  = wcnt_q;
        valid_d = valid_q;
        data_d  = data_q;
        user_d  = user_q;
        last_d  = last_q;
`ifdef AXIS_FRAME_BUILDER_CSUM_EN
        csum_d  = csum_q;
`endif
        // An accepted word leaves the register empty unless something new loads this cycle.
        if (slot_free) begin
            valid_d = 1'b0;
        end

        unique case (state_q)
            StHdr: begin
                // Header is launched by a pending sample but does not consume it.
                if (axis_s_tvalid && slot_free) begin
                    valid_d = 1'b1;
                    data_d  = '0;
                    data_d[HDR_SEQ_MSB:HDR_SEQ_LSB] = seq_q;
                    data_d[HDR_LEN_MSB:HDR_LEN_LSB] = LEN_FIELD;
                    user_d  = '0;
                    last_d  = 1'b0;
                    state_d = StPay;
                end
            end
            StPay: begin
                if (axis_s_tvalid && slot_free) begin
                    valid_d = 1'b1;
                    data_d  = axis_s_tdata;
                    user_d  = axis_s_tuser;
                    last_d  = 1'b0;
                    wcnt_d  = wcnt_q + WCNT_W'(1);
`ifdef AXIS_FRAME_BUILDER_CSUM_EN
                    csum_d  = csum_q + axis_s_tdata[CSUM_W-1:0];
`endif
                    if (wcnt_q == WCNT_LAST) begin
                        wcnt_d  = '0;
`ifdef AXIS_FRAME_BUILDER_CSUM_EN
                        state_d = StCsum;
`else
                        last_d  = 1'b1;
                        seq_d   = seq_q + SEQ_W'(1);
                        state_d = StHdr;
`endif
                    end
                end
            end
`ifdef AXIS_FRAME_BUILDER_CSUM_EN
            StCsum: begin
                if (slot_free) begin
                    valid_d = 1'b1;
                    data_d  = '0;
                    data_d[CSUM_W-1:0] = csum_q;
                    user_d  = '0;
                    last_d  = 1'b1;
                    csum_d  = '0;
                    seq_d   = seq_q + SEQ_W'(1);
                    state_d = StHdr;
                end
            end
`endif
            default: begin
                state_d = StHdr;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StHdr;
            seq_q   <= '0;
            wcnt_q  <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            user_q  <= '0;
            last_q  <= 1'b0;
`ifdef AXIS_FRAME_BUILDER_CSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            seq_q   <= seq_d;
            wcnt_q  <= wcnt_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            user_q  <= user_d;
            last_q  <= last_d;
`ifdef AXIS_FRAME_BUILDER_CSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

endmodule
